// File: rtl/pal_pkg.sv
// Shared constants, types and sizing helpers for the PAL configuration loader.
package pal_pkg;

    localparam int unsigned NUM_INPUTS_DEF        = 8;
    localparam int unsigned NUM_INTERM_STAGES_DEF = 14;
    localparam int unsigned NUM_OUTPUTS_DEF       = 4;
    localparam logic [7:0]  CRC8_POLY             = 8'h07;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BYTE = 3'd1,
        SHIFT_LO  = 3'd2,
        SHIFT_HI  = 3'd3,
        CHECK     = 3'd4,
        FINISH    = 3'd5,
        FAIL      = 3'd6
    } pal_state_e;

    // AND-plane (true and complement per input) plus OR-plane bits.
    function automatic int unsigned bitstream_len(input int unsigned ni,
                                                  input int unsigned ns,
                                                  input int unsigned no);
        return 2 * ni * ns + ns * no;
    endfunction

    function automatic int unsigned num_cfg_bytes(input int unsigned len);
        return (len + 7) / 8;
    endfunction

endpackage

// File: rtl/pal_cfg_crc8.sv
// Byte-wide CRC-8 accumulator (MSB-first, init 0x00); only exists when
// PAL_CFG_CRC_EN is defined.
`ifdef PAL_CFG_CRC_EN
module pal_cfg_crc8
    import pal_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       update,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    logic [7:0] crc_next;

    // Fold one byte into the running CRC, eight polynomial steps.
    always_comb begin
        crc_next = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[7] ? (8'(crc_next << 1) ^ CRC8_POLY) : 8'(crc_next << 1);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 8'h00;
        end else if (clear) begin
            crc <= 8'h00;
        end else if (update) begin
            crc <= crc_next;
        end
    end

endmodule
`endif

// File: rtl/pal_cfg_loader.sv
// Streams a byte-fed configuration bitstream into a PAL serial chain.
// Optional feature: PAL_CFG_CRC_EN appends a CRC-8 byte that is checked
// before the PAL outputs are enabled.
module pal_cfg_loader
    import pal_pkg::*;
#(
    parameter int unsigned NUM_INPUTS        = NUM_INPUTS_DEF,
    parameter int unsigned NUM_INTERM_STAGES = NUM_INTERM_STAGES_DEF,
    parameter int unsigned NUM_OUTPUTS       = NUM_OUTPUTS_DEF,
    parameter int unsigned CLK_DIV           = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       cfg_data,
    output logic       cfg_clk,
    output logic       pal_enable,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned LEN   = bitstream_len(NUM_INPUTS, NUM_INTERM_STAGES, NUM_OUTPUTS);
    localparam int unsigned BIT_W = $clog2(LEN + 1);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(LEN - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    pal_state_e       state_q;
    pal_state_e       state_d;
    logic [DIV_W-1:0] div_q;
    logic [BIT_W-1:0] bit_q;
    logic [7:0]       sh_q;
    logic             start_take;
    logic             byte_take;
    logic             div_end;
    logic             last_bit;
    logic             byte_end;
    logic             check_pass;

    assign start_take = start && (state_q == IDLE || state_q == FINISH || state_q == FAIL);
    assign byte_take  = byte_valid && (state_q == WAIT_BYTE);
    assign div_end    = (div_q == DIV_LAST);
    assign last_bit   = (bit_q == LAST_BIT);
    assign byte_end   = (bit_q[2:0] == 3'd7);

`ifdef PAL_CFG_CRC_EN
    logic       all_shifted;
    logic [7:0] crc_val;
    logic [7:0] crc_rx;

    assign all_shifted = (bit_q == BIT_W'(LEN));

    pal_cfg_crc8 u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_take),
        .update (byte_take && !all_shifted),
        .data   (byte_in),
        .crc    (crc_val)
    );

    // Capture the trailing CRC byte once the whole bitstream has gone out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_rx <= 8'h00;
        end else if (byte_take && all_shifted) begin
            crc_rx <= byte_in;
        end
    end

    assign check_pass = (crc_rx == crc_val);

    // Sticky failure flag, cleared by a new load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error <= 1'b0;
        end else if (start_take) begin
            error <= 1'b0;
        end else if (state_q == CHECK && !check_pass) begin
            error <= 1'b1;
        end
    end
`else
    assign check_pass = 1'b1;
    assign error      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured outside a load.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, FINISH, FAIL: begin
                if (start) state_d = WAIT_BYTE;
            end
            WAIT_BYTE: begin
                if (byte_valid) begin
`ifdef PAL_CFG_CRC_EN
                    state_d = all_shifted ? CHECK : SHIFT_LO;
`else
                    state_d = SHIFT_LO;
`endif
                end
            end
            SHIFT_LO: begin
                if (div_end) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (div_end) begin
                    if (last_bit) begin
`ifdef PAL_CFG_CRC_EN
                        state_d = WAIT_BYTE;
`else
                        state_d = CHECK;
`endif
                    end else if (byte_end) begin
                        state_d = WAIT_BYTE;
                    end else begin
                        state_d = SHIFT_LO;
                    end
                end
            end
            CHECK:   state_d = check_pass ? FINISH : FAIL;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs, decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_ready <= 1'b0;
            cfg_data   <= 1'b0;
            cfg_clk    <= 1'b0;
            pal_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_q      <= '0;
            bit_q      <= '0;
            sh_q       <= 8'h00;
        end else begin
            byte_ready <= (state_d == WAIT_BYTE);
            cfg_clk    <= (state_d == SHIFT_HI);
            busy       <= (state_d == WAIT_BYTE) || (state_d == SHIFT_LO) ||
                          (state_d == SHIFT_HI)  || (state_d == CHECK);
            div_q      <= ((state_q == SHIFT_LO || state_q == SHIFT_HI) && !div_end)
                          ? div_q + DIV_W'(1) : '0;

            if (start_take) begin
                bit_q      <= '0;
                done       <= 1'b0;
                pal_enable <= 1'b0;
            end else if (state_q == SHIFT_HI && div_end) begin
                bit_q <= bit_q + BIT_W'(1);
            end

            if (state_q == CHECK && check_pass) begin
                done       <= 1'b1;
                pal_enable <= 1'b1;
            end

            // New data bit only ever appears together with cfg_clk falling/low.
            if (byte_take && state_d == SHIFT_LO) begin
                cfg_data <= byte_in[0];
                sh_q     <= byte_in >> 1;
            end else if (state_q == SHIFT_HI && state_d == SHIFT_LO) begin
                cfg_data <= sh_q[0];
                sh_q     <= sh_q >> 1;
            end
        end
    end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Self-checking bench for pal_cfg_loader: two instances (CLK_DIV=1 and 3),
// table of load scenarios plus reset-abort and restart sequences.
module tb_pal_cfg_loader;

    localparam int NB   = 35;
    localparam int LEN  = 2 * 8 * 14 + 14 * 4;
    localparam int CAPN = 8192;

    typedef struct {
        string      name;
        int         d;
        int         kind;
        logic [7:0] fill;
        int         stall_after;
        int         restart_at;
        int         crc_force;
        bit         exp_ok;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start, byte_valid, byte_ready, cfg_data, cfg_clk;
    logic [1:0] pal_enable, busy, done, error;
    logic [7:0] byte_in [2];
    logic [7:0] stim [NB];

    int tests = 0;
    int fails = 0;

    logic cap [2][CAPN];
    int   ncap [2] = '{0, 0};
    int   viol [2] = '{0, 0};
    logic prev_clk [2], prev_data [2], armed [2], saw_ready [2];
    int   hi_run [2], lo_run [2];

    always #5 clk = ~clk;

    pal_cfg_loader #(.CLK_DIV(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .byte_in(byte_in[0]),
        .byte_valid(byte_valid[0]), .byte_ready(byte_ready[0]), .cfg_data(cfg_data[0]),
        .cfg_clk(cfg_clk[0]), .pal_enable(pal_enable[0]), .busy(busy[0]),
        .done(done[0]), .error(error[0])
    );

    pal_cfg_loader #(.CLK_DIV(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .byte_in(byte_in[1]),
        .byte_valid(byte_valid[1]), .byte_ready(byte_ready[1]), .cfg_data(cfg_data[1]),
        .cfg_clk(cfg_clk[1]), .pal_enable(pal_enable[1]), .busy(busy[1]),
        .done(done[1]), .error(error[1])
    );

    function automatic int div_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [6:0] outs(input int d);
        return {byte_ready[d], cfg_data[d], cfg_clk[d], pal_enable[d], busy[d], done[d], error[d]};
    endfunction

    // Observe the serial interface: capture a bit per cfg_clk rise and count
    // protocol violations (phase lengths, data moving while high, enables).
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int v;
            v = 0;
            if (!rst_n) begin
                prev_clk[g]  <= 1'b0;
                prev_data[g] <= 1'b0;
                armed[g]     <= 1'b0;
                saw_ready[g] <= 1'b0;
                hi_run[g]    <= 0;
                lo_run[g]    <= 0;
            end else begin
                if (cfg_clk[g]) begin
                    if (!prev_clk[g]) begin
                        cap[g][ncap[g] % CAPN] <= cfg_data[g];
                        ncap[g] <= ncap[g] + 1;
                        if (!busy[g]) v++;
                        if (armed[g] && !saw_ready[g] && lo_run[g] != div_of(g)) v++;
                        hi_run[g] <= 1;
                    end else begin
                        hi_run[g] <= hi_run[g] + 1;
                    end
                    if (cfg_data[g] !== prev_data[g]) v++;
                end else begin
                    if (prev_clk[g]) begin
                        if (hi_run[g] != div_of(g)) v++;
                        lo_run[g]    <= 1;
                        saw_ready[g] <= byte_ready[g];
                    end else begin
                        lo_run[g]    <= lo_run[g] + 1;
                        saw_ready[g] <= saw_ready[g] | byte_ready[g];
                    end
                end
                if (!busy[g])                 armed[g] <= 1'b0;
                else if (!cfg_clk[g] && prev_clk[g]) armed[g] <= 1'b1;
                if (busy[g] && pal_enable[g]) v++;
                if (byte_ready[g] && !busy[g]) v++;
                prev_clk[g]  <= cfg_clk[g];
                prev_data[g] <= cfg_data[g];
                viol[g] <= viol[g] + v;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

`ifdef PAL_CFG_CRC_EN
    // Bit-serial CRC-8 over the stimulus bytes, MSB of each byte first.
    function automatic logic [7:0] crc8_model();
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < NB; i++) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[7] ^ stim[i][k];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction
`endif

    task automatic send_byte(input int d, input logic [7:0] val, input string nm, output bit ok);
        ok = 1'b0;
        byte_in[d]    = val;
        byte_valid[d] = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            if (byte_ready[d] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        byte_valid[d] = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s: byte_ready timeout, got 0 expected 1", nm);
        end
    endtask

    function automatic vec_t mk(input string nm, input int d, input int kind, input logic [7:0] fill,
                                input int stall_after, input int restart_at,
                                input int crc_force, input bit exp_ok);
        vec_t v;
        v.name = nm; v.d = d; v.kind = kind; v.fill = fill;
        v.stall_after = stall_after; v.restart_at = restart_at;
        v.crc_force = crc_force; v.exp_ok = exp_ok;
        return v;
    endfunction

    // One complete load, then compare against the bitstream expected from stim.
    task automatic run_vec(input vec_t v);
        int  d, base, vb, n, bm, highs;
        bit  ok;
        logic [7:0] crcb;
        d = v.d;
        for (int i = 0; i < NB; i++) begin
            case (v.kind)
                0:       stim[i] = v.fill;
                1:       stim[i] = (i == 0) ? 8'h01 : 8'h00;
                default: stim[i] = 8'($urandom);
            endcase
        end
        crcb = 8'h00;
`ifdef PAL_CFG_CRC_EN
        crcb = (v.crc_force >= 0) ? 8'(v.crc_force) : crc8_model();
`endif
        #1;
        base = ncap[d];
        vb   = viol[d];
        @(negedge clk);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        for (int b = 0; b < NB; b++) begin
            send_byte(d, stim[b], v.name, ok);
            if (!ok) return;
            if (b == v.restart_at) begin
                start[d] = 1'b1;
                @(negedge clk);
                start[d] = 1'b0;
            end
            if (b == v.stall_after) begin
                for (int t = 0; t < 1000 && byte_ready[d] !== 1'b1; t++) @(negedge clk);
                highs = 0;
                for (int t = 0; t < 20; t++) begin
                    if (cfg_clk[d] || !byte_ready[d]) highs++;
                    @(negedge clk);
                end
                check({v.name, "_stall_static"}, highs, 0);
            end
        end
`ifdef PAL_CFG_CRC_EN
        send_byte(d, crcb, v.name, ok);
        if (!ok) return;
`endif
        for (int t = 0; t < 500 && busy[d] !== 1'b0; t++) @(negedge clk);
        #1;
        check({v.name, "_busy_end"}, busy[d], 0);
        n = ncap[d] - base;
        check({v.name, "_pulses"}, n, LEN);
        bm = 0;
        for (int i = 0; i < LEN && i < n; i++) begin
            if (cap[d][(base + i) % CAPN] !== stim[i / 8][i % 8]) bm++;
        end
        check({v.name, "_bit_errs"}, bm, 0);
        check({v.name, "_done"}, done[d], v.exp_ok);
        check({v.name, "_pal_enable"}, pal_enable[d], v.exp_ok);
        check({v.name, "_error"}, error[d], !v.exp_ok);
        check({v.name, "_protocol"}, viol[d] - vb, 0);
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [9];
        int   base, vb;
        bit   ok;

        vecs[0] = mk("onehot_b0",   0, 1, 8'h00, -1, -1, -1, 1'b1);
        vecs[1] = mk("all_ones",    0, 0, 8'hFF, -1, -1, -1, 1'b1);
        vecs[2] = mk("fill_a5",     0, 0, 8'hA5, -1, -1, -1, 1'b1);
        vecs[3] = mk("rand_div1",   0, 2, 8'h00, -1, -1, -1, 1'b1);
        vecs[4] = mk("rand_div3",   1, 2, 8'h00, -1, -1, -1, 1'b1);
        vecs[5] = mk("stall_div1",  0, 2, 8'h00, 10, -1, -1, 1'b1);
        vecs[6] = mk("stall_div3",  1, 2, 8'h00, 10, -1, -1, 1'b1);
        vecs[7] = mk("restart_d1",  0, 2, 8'h00, -1,  5, -1, 1'b1);
        vecs[8] = mk("restart_d3",  1, 2, 8'h00, -1, 20, -1, 1'b1);

        rst_n = 1'b0;
        start = 2'b00;
        byte_valid = 2'b00;
        byte_in[0] = 8'h00;
        byte_in[1] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outs_d0", outs(0), 0);
        check("reset_outs_d1", outs(1), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // A new start clears the sticky status and raises busy next cycle.
        check("pre_start_done", done[0], 1);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check("start_clears_done", done[0], 0);
        check("start_busy", busy[0], 1);
        check("start_byte_ready", byte_ready[0], 1);
        check("start_pal_off", pal_enable[0], 0);

        // Abort with reset after byte 17, mid-shift.
        for (int i = 0; i < NB; i++) stim[i] = 8'($urandom);
        for (int b = 0; b <= 17; b++) begin
            send_byte(0, stim[b], "abort_load", ok);
        end
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outs_zero", outs(0), 0);
        base = ncap[0];
        vb   = viol[0];
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("abort_no_edges", ncap[0] - base, 0);
        check("abort_outs_idle", outs(0), 0);
        check("abort_protocol", viol[0] - vb, 0);
        run_vec(mk("after_abort", 0, 2, 8'h00, -1, -1, -1, 1'b1));

`ifdef PAL_CFG_CRC_EN
        run_vec(mk("crc_zero_ok",  0, 0, 8'h00, -1, -1, 8'h00, 1'b1));
        run_vec(mk("crc_zero_bad", 0, 0, 8'h00, -1, -1, 8'h5A, 1'b0));
        run_vec(mk("crc_rand_ok",  1, 2, 8'h00, -1, -1, -1,    1'b1));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
